id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register placed directly downstream of the register file; it captures ReadData1/ReadData2.
//  Forwards from the EX, MEM and WB stages, producing operands for the EX stage.
//  Detects load-use hazards and honours downstream stalls and branch flushes.
//  Drives ID_Stall, which holds the PC and IF/ID. Also counts stall cycles.
// PARAMETERS
//  CTRL_W   12  width of the decoded control bundle passed through to EX
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  Clk          in   1       clock; all state updates on rising edge
//  Reset        in   1       synchronous, active-high reset
//  ID_Valid     in   1       ID holds a real instruction
//  ID_Rs/ID_Rt  in   5       source register numbers
//  ID_UsesRs/Rt in   1       instruction actually reads rs / rt
//  ID_WriteReg  in   5       destination register (already rd/rt/31 selected)
//  ID_Imm       in   32      sign/zero-extended immediate
//  ID_Ctrl      in   CTRL_W  decoded control bundle
//  ID_MemRead   in   1       instruction is a load
//  ReadData1/2  in   32      register-file outputs, valid after falling edge
//  EXR_Result   in   32      ALU result of instruction now in EX
//  MEM_RegWrite in   1       MEM-stage write enable; MEM_WriteReg in 5; MEM_Data in 32
//  WB_RegWrite  in   1       WB-stage write enable;  WB_WriteReg in 5;  WB_Data in 32
//  EX_Stall     in   1       EX/MEM busy (multi-cycle op); hold ID/EX
//  Flush        in   1       branch/jump taken; kill instruction in ID
//  ID_Stall     out  1       hold PC and IF/ID this cycle (combinational)
//  EX_Valid, EX_RegWrite, EX_MemRead  out 1;  EX_Rs, EX_Rt, EX_WriteReg  out 5
//  EX_Data1/2, EX_Imm  out 32;  EX_Ctrl  out CTRL_W
//  StallCount   out  CNT_W   cycles with ID_Stall=1 since reset, saturating
// BEHAVIOUR
//  - Reset: every output register = 0; FSM = RUN; FlushPend = 0; StallCount = 0.
//  - Latency: 1 cycle; ID fields captured at the rising edge appear on EX_* outputs.
//  - Forwarding per operand, chosen at capture; reg 0 is never forwarded (operand = ReadDataN).
//    Priority: EX (EX_Valid & EX_RegWrite & !EX_MemRead & EX_WriteReg==src) -> EXR_Result;
//    else MEM match -> MEM_Data; else WB match -> WB_Data; else ReadDataN.
//  - LoadUse = ID_Valid & EX_Valid & EX_MemRead & EX_WriteReg!=0 &
//    ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
//  - FSM states: RUN, LDSTALL, HOLD.
//    - RUN: EX_Stall -> HOLD. Else LoadUse & !Flush -> LDSTALL: insert bubble (EX_Valid<=0), ID_Stall=1.
//      Else capture ID (EX_Valid <= ID_Valid & !Flush).
//    - LDSTALL: exactly one bubble cycle; ID_Stall=0; capture ID with MEM forwarding -> RUN.
//      EX_Stall -> HOLD.
//    - HOLD: all EX_* held; ID_Stall=1; leave to RUN the first cycle EX_Stall=0.
//  - Bubble: EX_Valid, EX_RegWrite, EX_MemRead and Ctrl write/mem bits = 0; data fields don't-care (zeroed).
//  - Flush:
//    - In RUN: the ID instruction enters EX as a bubble, and Flush overrides LoadUse.
//    - In HOLD: set FlushPend; on exit, the first capture becomes a bubble and FlushPend clears.
//  - Simultaneous:
//    - EX_Stall beats LoadUse and Flush.
//    - Reset beats everything, including mid-HOLD and mid-LDSTALL.
//  - ID_Stall = (RUN & LoadUse & !Flush & !EX_Stall) | EX_Stall | HOLD.
//  - StallCount += 1 each cycle ID_Stall=1; it stops at all-ones.
// STRUCTURE
//  - Shared package pipeline_pkg:
//    - CTRL_W and control-bundle bit indices (RegWrite, MemRead, MemWrite, ALUOp...).
//    - FSM state encoding (RUN=0, LDSTALL=1, HOLD=2) and the BUBBLE control constant.
//  - One sub-module: fwd_mux (src reg, regfile data, three stage matches -> operand); instantiated twice.
// TESTING
//  1. Reset high 2 cycles mid-stream -> all EX_* = 0, ID_Stall=0, StallCount=0.
//  2. EX: add $3 (EXR_Result=0x15); ID reads $3 with ReadData1=0x0 -> EX_Data1=0x15 next cycle, no stall.
//  3. EX: lw $5; ID: add uses $5 -> ID_Stall=1 one cycle, bubble; next cycle EX_Data=MEM_Data=0xCAFE, StallCount=1.
//  4. $0 match with MEM_WriteReg=0, MEM_Data=0xFFFF -> EX_Data1=ReadData1=0.
//  5. EX_Stall high 3 cycles with Flush pulsed in cycle 2 -> EX_* frozen, ID_Stall=1 x3, first capture after release is a bubble.
//  6. Same reg matched in MEM (0x11) and WB (0x22) -> operand 0x11.
//     Also force StallCount to 0xFFFF and stall once more -> stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, ID/EX FSM encoding,
// bubble constant and the register-match helper used by forwarding.
package pipeline_pkg;

    localparam int CTRL_W = 12;

    // Control bundle bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_ALUOP_HI = 6;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_HOLD    = 2'd2
    } stage_state_e;

    // A bubble carries no write or memory side effects; the whole bundle is cleared.
    localparam logic [CTRL_W-1:0] BUBBLE = {CTRL_W{1'b0}};

    // True when an enabled producer writes the source register; $0 never matches.
    function automatic logic reg_match(input logic       en,
                                       input logic [4:0] dst,
                                       input logic [4:0] src);
        return en && (dst == src) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest producer of a source register,
// falling back to the register-file value.
module fwd_mux
    import pipeline_pkg::*;
(
    input  logic [4:0]  i_src,
    input  logic [31:0] i_rf_data,
    input  logic        i_ex_en,
    input  logic [4:0]  i_ex_reg,
    input  logic [31:0] i_ex_data,
    input  logic        i_mem_en,
    input  logic [4:0]  i_mem_reg,
    input  logic [31:0] i_mem_data,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_operand
);

    // Priority select: EX over MEM over WB over register file.
    always_comb begin
        o_operand = i_rf_data;
        if (reg_match(i_ex_en, i_ex_reg, i_src)) begin
            o_operand = i_ex_data;
        end else if (reg_match(i_mem_en, i_mem_reg, i_src)) begin
            o_operand = i_mem_data;
        end else if (reg_match(i_wb_en, i_wb_reg, i_src)) begin
            o_operand = i_wb_data;
        end else begin
            o_operand = i_rf_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use interlock,
// downstream-stall hold, branch flush and a saturating stall-cycle counter.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int CTRL_W = pipeline_pkg::CTRL_W,
    parameter int CNT_W  = 16
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic [4:0]        ID_WriteReg,
    input  logic [31:0]       ID_Imm,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic              ID_MemRead,
    input  logic [31:0]       ReadData1,
    input  logic [31:0]       ReadData2,
    input  logic [31:0]       EXR_Result,
    input  logic              MEM_RegWrite,
    input  logic [4:0]        MEM_WriteReg,
    input  logic [31:0]       MEM_Data,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteReg,
    input  logic [31:0]       WB_Data,
    input  logic              EX_Stall,
    input  logic              Flush,
    output logic              ID_Stall,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_WriteReg,
    output logic [31:0]       EX_Data1,
    output logic [31:0]       EX_Data2,
    output logic [31:0]       EX_Imm,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [CNT_W-1:0]  StallCount
);

    stage_state_e      r_state;
    stage_state_e      w_next_state;
    logic              r_flush_pend;
    logic              r_ex_valid, r_ex_regwrite, r_ex_memread;
    logic [4:0]        r_ex_rs, r_ex_rt, r_ex_wr;
    logic [31:0]       r_ex_d1, r_ex_d2, r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic        w_kill, w_load_use, w_ex_fwd_en;
    logic        w_id_stall, w_capture, w_bubble;
    logic [31:0] w_op1, w_op2;

    // A pending flush from a held cycle kills the next captured instruction.
    assign w_kill      = Flush | r_flush_pend;
    // A load in EX cannot forward; only ALU results are taken from EX.
    assign w_ex_fwd_en = r_ex_valid & r_ex_regwrite & ~r_ex_memread;
    assign w_load_use  = ID_Valid & r_ex_valid & r_ex_memread & (r_ex_wr != 5'd0) &
                         ((ID_UsesRs & (ID_Rs == r_ex_wr)) | (ID_UsesRt & (ID_Rt == r_ex_wr)));

    fwd_mux u_fwd_rs (
        .i_src(ID_Rs), .i_rf_data(ReadData1),
        .i_ex_en(w_ex_fwd_en), .i_ex_reg(r_ex_wr), .i_ex_data(EXR_Result),
        .i_mem_en(MEM_RegWrite), .i_mem_reg(MEM_WriteReg), .i_mem_data(MEM_Data),
        .i_wb_en(WB_RegWrite), .i_wb_reg(WB_WriteReg), .i_wb_data(WB_Data),
        .o_operand(w_op1)
    );

    fwd_mux u_fwd_rt (
        .i_src(ID_Rt), .i_rf_data(ReadData2),
        .i_ex_en(w_ex_fwd_en), .i_ex_reg(r_ex_wr), .i_ex_data(EXR_Result),
        .i_mem_en(MEM_RegWrite), .i_mem_reg(MEM_WriteReg), .i_mem_data(MEM_Data),
        .i_wb_en(WB_RegWrite), .i_wb_reg(WB_WriteReg), .i_wb_data(WB_Data),
        .o_operand(w_op2)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a downstream stall takes precedence over everything else.
    always_comb begin
        w_next_state = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (EX_Stall) begin
                    w_next_state = ST_HOLD;
                end else if (w_load_use && !w_kill) begin
                    w_next_state = ST_LDSTALL;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_LDSTALL: begin
                if (EX_Stall) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (EX_Stall) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // FSM outputs: upstream stall, capture of ID, or bubble insertion.
    always_comb begin
        w_id_stall = 1'b0;
        w_capture  = 1'b0;
        w_bubble   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (EX_Stall) begin
                    w_id_stall = 1'b1;
                end else if (w_load_use && !w_kill) begin
                    w_id_stall = 1'b1;
                    w_bubble   = 1'b1;
                end else begin
                    w_capture  = 1'b1;
                end
            end
            ST_LDSTALL: begin
                if (EX_Stall) begin
                    w_id_stall = 1'b1;
                end else begin
                    w_capture  = 1'b1;
                end
            end
            ST_HOLD: begin
                w_id_stall = 1'b1;
            end
            default: begin
                w_id_stall = 1'b0;
            end
        endcase
    end

    // ID/EX payload register: bubble, capture (killed or real) or hold.
    always_ff @(posedge Clk) begin
        if (Reset || w_bubble || (w_capture && !(ID_Valid && !w_kill))) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_rs       <= 5'd0;
            r_ex_rt       <= 5'd0;
            r_ex_wr       <= 5'd0;
            r_ex_d1       <= 32'd0;
            r_ex_d2       <= 32'd0;
            r_ex_imm      <= 32'd0;
            r_ex_ctrl     <= BUBBLE;
        end else if (w_capture) begin
            r_ex_valid    <= 1'b1;
            r_ex_regwrite <= ID_Ctrl[CTRL_REGWRITE];
            r_ex_memread  <= ID_MemRead;
            r_ex_rs       <= ID_Rs;
            r_ex_rt       <= ID_Rt;
            r_ex_wr       <= ID_WriteReg;
            r_ex_d1       <= w_op1;
            r_ex_d2       <= w_op2;
            r_ex_imm      <= ID_Imm;
            r_ex_ctrl     <= ID_Ctrl;
        end else begin
            r_ex_valid    <= r_ex_valid;
        end
    end

    // Remember a flush that arrives while ID is held so the held instruction dies later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flush_pend <= 1'b0;
        end else if (Flush && (EX_Stall || (r_state == ST_HOLD))) begin
            r_flush_pend <= 1'b1;
        end else if (w_capture) begin
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= r_flush_pend;
        end
    end

    // Saturating count of cycles in which ID is stalled.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_id_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign ID_Stall    = w_id_stall;
    assign EX_Valid    = r_ex_valid;
    assign EX_RegWrite = r_ex_regwrite;
    assign EX_MemRead  = r_ex_memread;
    assign EX_Rs       = r_ex_rs;
    assign EX_Rt       = r_ex_rt;
    assign EX_WriteReg = r_ex_wr;
    assign EX_Data1    = r_ex_d1;
    assign EX_Data2    = r_ex_d2;
    assign EX_Imm      = r_ex_imm;
    assign EX_Ctrl     = r_ex_ctrl;
    assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of per-cycle vectors with a
// scoreboard queue of expected EX outputs, plus reset and saturation sequences.
module tb_id_ex_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ID_Valid, ID_UsesRs, ID_UsesRt, ID_MemRead;
    logic [4:0]  ID_Rs, ID_Rt, ID_WriteReg;
    logic [31:0] ID_Imm, ReadData1, ReadData2, EXR_Result, MEM_Data, WB_Data;
    logic [11:0] ID_Ctrl;
    logic        MEM_RegWrite, WB_RegWrite, EX_Stall, Flush;
    logic [4:0]  MEM_WriteReg, WB_WriteReg;
    logic        ID_Stall, EX_Valid, EX_RegWrite, EX_MemRead;
    logic [4:0]  EX_Rs, EX_Rt, EX_WriteReg;
    logic [31:0] EX_Data1, EX_Data2, EX_Imm;
    logic [11:0] EX_Ctrl;
    logic [15:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.CTRL_W(12), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg),
        .ID_Imm(ID_Imm), .ID_Ctrl(ID_Ctrl), .ID_MemRead(ID_MemRead),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .EXR_Result(EXR_Result),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .MEM_Data(MEM_Data),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_Data(WB_Data),
        .EX_Stall(EX_Stall), .Flush(Flush), .ID_Stall(ID_Stall), .EX_Valid(EX_Valid),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
        .EX_WriteReg(EX_WriteReg), .EX_Data1(EX_Data1), .EX_Data2(EX_Data2),
        .EX_Imm(EX_Imm), .EX_Ctrl(EX_Ctrl), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        id_valid;
        logic [4:0]  rs, rt;
        logic        urs, urt;
        logic [4:0]  wr;
        logic [11:0] ctrl;
        logic        memread;
        logic [31:0] rd1, rd2, exr;
        logic        mem_rw;
        logic [4:0]  mem_wr;
        logic [31:0] mem_d;
        logic        wb_rw;
        logic [4:0]  wb_wr;
        logic [31:0] wb_d;
        logic        ex_stall, flush;
        logic        e_stall, e_valid;
        logic [31:0] e_d1, e_d2;
        logic [4:0]  e_wr;
        logic        e_mr;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] d1, d2;
        logic [4:0]  wr;
        logic        mr;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk_id(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] wr,
                                   logic [11:0] ctrl, logic mr, logic [31:0] rd1, logic [31:0] rd2);
        vec_t t;
        t = '0;
        t.id_valid = v; t.rs = rs; t.rt = rt; t.urs = 1'b1; t.urt = 1'b1;
        t.wr = wr; t.ctrl = ctrl; t.memread = mr; t.rd1 = rd1; t.rd2 = rd2;
        return t;
    endfunction

    function automatic vec_t with_exp(vec_t t, logic st, logic v, logic [31:0] d1, logic [31:0] d2,
                                      logic [4:0] wr, logic mr, logic [15:0] cnt);
        vec_t r;
        r = t;
        r.e_stall = st; r.e_valid = v; r.e_d1 = d1; r.e_d2 = d2;
        r.e_wr = wr; r.e_mr = mr; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        ID_Valid = t.id_valid; ID_Rs = t.rs; ID_Rt = t.rt; ID_UsesRs = t.urs; ID_UsesRt = t.urt;
        ID_WriteReg = t.wr; ID_Ctrl = t.ctrl; ID_MemRead = t.memread; ID_Imm = 32'h0000_0004;
        ReadData1 = t.rd1; ReadData2 = t.rd2; EXR_Result = t.exr;
        MEM_RegWrite = t.mem_rw; MEM_WriteReg = t.mem_wr; MEM_Data = t.mem_d;
        WB_RegWrite = t.wb_rw; WB_WriteReg = t.wb_wr; WB_Data = t.wb_d;
        EX_Stall = t.ex_stall; Flush = t.flush;
    endtask

    // One cycle: drive at negedge, check ID_Stall, push expectation, compare after the edge.
    task automatic apply(vec_t t, string tag);
        exp_t e;
        @(negedge Clk);
        drive(t);
        #1;
        chk({tag, "_idstall"}, {31'd0, ID_Stall}, {31'd0, t.e_stall});
        sb.push_back('{valid: t.e_valid, d1: t.e_d1, d2: t.e_d2, wr: t.e_wr, mr: t.e_mr, cnt: t.e_cnt});
        @(posedge Clk);
        #1;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", tag);
        end else begin
            n_tests--;
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, EX_Valid}, {31'd0, e.valid});
            chk({tag, "_d1"}, EX_Data1, e.d1);
            chk({tag, "_d2"}, EX_Data2, e.d2);
            chk({tag, "_wr"}, {27'd0, EX_WriteReg}, {27'd0, e.wr});
            chk({tag, "_memread"}, {31'd0, EX_MemRead}, {31'd0, e.mr});
            chk({tag, "_cnt"}, {16'd0, StallCount}, {16'd0, e.cnt});
        end
    endtask

    task automatic check_cleared(string tag);
        chk({tag, "_valid"}, {31'd0, EX_Valid}, 32'd0);
        chk({tag, "_regwrite"}, {31'd0, EX_RegWrite}, 32'd0);
        chk({tag, "_d1"}, EX_Data1, 32'd0);
        chk({tag, "_wr"}, {27'd0, EX_WriteReg}, 32'd0);
        chk({tag, "_ctrl"}, {20'd0, EX_Ctrl}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, StallCount}, 32'd0);
    endtask

    initial begin
        vec_t t;
        vec_t idle;
        idle = '0;
        drive(idle);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_cleared("reset0");
        @(negedge Clk);
        Reset = 1'b0;

        // add $3 <- $1,$2
        tbl.push_back(with_exp(mk_id(1, 1, 2, 3, 12'h001, 0, 32'h10, 32'h20), 0, 1, 32'h10, 32'h20, 3, 0, 0));
        // reads $3 while add $3 in EX -> EXR_Result
        t = mk_id(1, 3, 4, 6, 12'h001, 0, 32'h0, 32'h44); t.exr = 32'h15;
        tbl.push_back(with_exp(t, 0, 1, 32'h15, 32'h44, 6, 0, 0));
        // lw $5
        t = mk_id(1, 7, 5, 5, 12'h003, 1, 32'h100, 32'h0); t.urt = 1'b0;
        tbl.push_back(with_exp(t, 0, 1, 32'h100, 32'h0, 5, 1, 0));
        // add uses $5 -> load-use bubble
        tbl.push_back(with_exp(mk_id(1, 5, 8, 9, 12'h001, 0, 32'h0, 32'h88), 1, 0, 0, 0, 0, 0, 1));
        // replay with load now in MEM
        t = mk_id(1, 5, 8, 9, 12'h001, 0, 32'h0, 32'h88);
        t.mem_rw = 1'b1; t.mem_wr = 5'd5; t.mem_d = 32'hCAFE;
        tbl.push_back(with_exp(t, 0, 1, 32'hCAFE, 32'h88, 9, 0, 1));
        // $0 is never forwarded
        t = mk_id(1, 0, 0, 10, 12'h001, 0, 32'h0, 32'h0);
        t.mem_rw = 1'b1; t.mem_wr = 5'd0; t.mem_d = 32'hFFFF;
        tbl.push_back(with_exp(t, 0, 1, 32'h0, 32'h0, 10, 0, 1));
        // MEM beats WB
        t = mk_id(1, 11, 12, 13, 12'h001, 0, 32'h1, 32'h2);
        t.mem_rw = 1'b1; t.mem_wr = 5'd11; t.mem_d = 32'h11;
        t.wb_rw = 1'b1; t.wb_wr = 5'd11; t.wb_d = 32'h22;
        tbl.push_back(with_exp(t, 0, 1, 32'h11, 32'h2, 13, 0, 1));
        // WB only for rs; EX beats MEM for rt
        t = mk_id(1, 11, 13, 14, 12'h001, 0, 32'h1, 32'h2);
        t.exr = 32'h77; t.mem_rw = 1'b1; t.mem_wr = 5'd13; t.mem_d = 32'h99;
        t.wb_rw = 1'b1; t.wb_wr = 5'd11; t.wb_d = 32'h22;
        tbl.push_back(with_exp(t, 0, 1, 32'h22, 32'h77, 14, 0, 1));
        // lw $15
        t = mk_id(1, 0, 15, 15, 12'h003, 1, 32'h200, 32'h0); t.urt = 1'b0;
        tbl.push_back(with_exp(t, 0, 1, 32'h200, 32'h0, 15, 1, 1));
        // load-use with Flush: flush wins, bubble, no stall
        t = mk_id(1, 15, 0, 16, 12'h001, 0, 32'h5, 32'h6); t.flush = 1'b1;
        tbl.push_back(with_exp(t, 0, 0, 0, 0, 0, 0, 1));
        // normal capture after flushed bubble
        tbl.push_back(with_exp(mk_id(1, 15, 1, 17, 12'h001, 0, 32'h7, 32'h8), 0, 1, 32'h7, 32'h8, 17, 0, 1));
        // invalid ID becomes a bubble
        tbl.push_back(with_exp(mk_id(0, 1, 2, 18, 12'h001, 0, 32'h9, 32'hA), 0, 0, 0, 0, 0, 0, 1));
        // EX_Stall x3 with Flush in cycle 2, then exit and flushed capture
        tbl.push_back(with_exp(mk_id(1, 1, 2, 18, 12'h001, 0, 32'hAA, 32'hBB), 0, 1, 32'hAA, 32'hBB, 18, 0, 1));
        t = mk_id(1, 1, 2, 19, 12'h001, 0, 32'hDD, 32'hEE); t.ex_stall = 1'b1;
        tbl.push_back(with_exp(t, 1, 1, 32'hAA, 32'hBB, 18, 0, 2));
        t.flush = 1'b1;
        tbl.push_back(with_exp(t, 1, 1, 32'hAA, 32'hBB, 18, 0, 3));
        t.flush = 1'b0;
        tbl.push_back(with_exp(t, 1, 1, 32'hAA, 32'hBB, 18, 0, 4));
        t.ex_stall = 1'b0;
        tbl.push_back(with_exp(t, 1, 1, 32'hAA, 32'hBB, 18, 0, 5));
        tbl.push_back(with_exp(t, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(with_exp(t, 0, 1, 32'hDD, 32'hEE, 19, 0, 5));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Reset mid-HOLD: enter HOLD, then reset for 2 cycles while inputs stay busy.
        t = mk_id(1, 1, 2, 20, 12'h001, 0, 32'h1234, 32'h5678);
        t.ex_stall = 1'b1;
        @(negedge Clk);
        drive(t);
        @(negedge Clk);
        Reset = 1'b1;
        t.ex_stall = 1'b0;
        drive(t);
        repeat (2) @(posedge Clk);
        #1;
        check_cleared("reset_hold");
        @(negedge Clk);
        Reset = 1'b0;
        drive(idle);
        #1;
        chk("reset_hold_idstall", {31'd0, ID_Stall}, 32'd0);

        // Saturation: 65535 stalled cycles reach all-ones, one more keeps it there.
        @(negedge Clk);
        EX_Stall = 1'b1;
        repeat (65535) @(posedge Clk);
        #1;
        chk("sat_reach", {16'd0, StallCount}, 32'h0000_FFFF);
        @(posedge Clk);
        #1;
        chk("sat_hold", {16'd0, StallCount}, 32'h0000_FFFF);
        @(negedge Clk);
        EX_Stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
